// File: rtl/stream_check_pkg.sv
// stream_check_pkg
// Shared definitions for the write-test stream checker:
//   - pattern codes understood by the reference generator
//   - seed values and LFSR tap positions for each pattern
//   - seed_for(code)          : generator value right after (re)seeding
//   - next_pattern(code, g)   : generator value after one advance
// Codes 5..7 are not named and fall back to the 64-bit counter.

package stream_check_pkg;

  localparam int STREAM_W = 64;

  typedef enum logic [2:0] {
    PAT_CNT64   = 3'd0,
    PAT_CNT32X2 = 3'd1,
    PAT_WALK1   = 3'd2,
    PAT_LFSR64  = 3'd3,
    PAT_ALT     = 3'd4
  } pattern_e;

  localparam logic [63:0] SEED_CNT64   = 64'h0000_0000_0000_0000;
  // Host counts in 32-bit words and packs the low word first, so the
  // first 64-bit beat carries {1, 0} and each half then steps by two.
  localparam logic [63:0] SEED_CNT32X2 = {32'd1, 32'd0};
  localparam logic [63:0] SEED_WALK1   = 64'h0000_0000_0000_0001;
  localparam logic [63:0] SEED_LFSR64  = 64'h0000_0000_0000_0001;
  localparam logic [63:0] SEED_ALT     = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] ALT_OTHER    = 64'h5555_5555_5555_5555;

  localparam logic [31:0] CNT32X2_STEP = 32'd2;

  // Feedback taps of the Fibonacci LFSR (x^64 + x^63 + x^61 + x^60 + 1).
  localparam int LFSR_TAP_A = 63;
  localparam int LFSR_TAP_B = 62;
  localparam int LFSR_TAP_C = 60;
  localparam int LFSR_TAP_D = 59;

  function automatic logic [63:0] seed_for(input logic [2:0] code);
    logic [63:0] seed;
    case (code)
      PAT_CNT32X2: seed = SEED_CNT32X2;
      PAT_WALK1:   seed = SEED_WALK1;
      PAT_LFSR64:  seed = SEED_LFSR64;
      PAT_ALT:     seed = SEED_ALT;
      default:     seed = SEED_CNT64;
    endcase
    return seed;
  endfunction

  function automatic logic [63:0] next_pattern(input logic [2:0] code,
                                               input logic [63:0] g);
    logic [63:0] nxt;
    logic        fb;
    fb = g[LFSR_TAP_A] ^ g[LFSR_TAP_B] ^ g[LFSR_TAP_C] ^ g[LFSR_TAP_D];
    case (code)
      PAT_CNT32X2: nxt = {g[63:32] + CNT32X2_STEP, g[31:0] + CNT32X2_STEP};
      PAT_WALK1:   nxt = {g[62:0], g[63]};
      PAT_LFSR64:  nxt = {g[62:0], fb};
      // Two-state toggle; anything other than the seed returns to the seed.
      PAT_ALT:     nxt = (g == SEED_ALT) ? ALT_OTHER : SEED_ALT;
      default:     nxt = g + 64'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen
// Reference word generator for the stream checker. Latches the pattern
// code and seeds the generator register on reset or reset_pattern, then
// advances one step per enable.
// Ports:
//   okClk         in   clock, rising edge
//   reset         in   synchronous active-high reset
//   reset_pattern in   re-latch pattern code and re-seed
//   pattern_sel   in   pattern code, sampled only on reset/reset_pattern
//   enable        in   advance strobe
//   word          out  current generator value G

module stream_pattern_gen
  import stream_check_pkg::*;
(
  input  logic        okClk,
  input  logic        reset,
  input  logic        reset_pattern,
  input  logic [2:0]  pattern_sel,
  input  logic        enable,
  output logic [63:0] word
);

  logic [2:0] code;

  // reset and reset_pattern both re-seed; enable is ignored on those
  // cycles so the first word after re-seeding is always the seed itself.
  always_ff @(posedge okClk) begin
    if (reset || reset_pattern) begin
      code <= pattern_sel;
      word <= seed_for(pattern_sel);
    end else if (enable) begin
      word <= next_pattern(code, word);
    end
  end

endmodule

// File: rtl/stream_pattern_checker.sv
// stream_pattern_checker
// Checks the 64-bit word stream read from the write-test FIFO against a
// locally generated reference. The generator advances on the FIFO read
// strobe (enable); the word it produced travels down a CHECK_LATENCY-deep
// expected pipe and is compared when the FIFO valid strobe (check) fires.
// Counts checks and word errors and keeps the first mismatch for readback.
//
// Optional build macro BIT_ERROR_COUNT_EN: adds a saturating count of
// mismatching bits (one extra cycle of latency). Without it the
// bit_error_count port is tied to zero.
//
// Ports:
//   okClk            in   clock, rising edge
//   reset            in   synchronous active-high, clears everything
//   reset_pattern    in   re-seed generator, flush expected pipe
//   pattern_sel[2:0] in   pattern code (sampled on reset/reset_pattern)
//   enable           in   generator advance strobe
//   check            in   data_in valid, compare this cycle
//   data_in[63:0]    in   word under test
//   expected_out     out  expected word at pipe tail
//   word_count       out  checks performed (wraps)
//   error_count      out  mismatching words (saturates)
//   first_err_valid  out  sticky, first mismatch captured
//   first_err_index  out  word_count at the first mismatch
//   first_err_data   out  data_in at the first mismatch
//   sync_err         out  sticky, check with no valid expected word
//   bit_error_count  out  mismatching bits (BIT_ERROR_COUNT_EN only)

module stream_pattern_checker
  import stream_check_pkg::*;
#(
  parameter int CHECK_LATENCY = 1,
  parameter int DATA_W        = 64
) (
  input  logic              okClk,
  input  logic              reset,
  input  logic              reset_pattern,
  input  logic [2:0]        pattern_sel,
  input  logic              enable,
  input  logic              check,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] expected_out,
  output logic [31:0]       word_count,
  output logic [31:0]       error_count,
  output logic              first_err_valid,
  output logic [31:0]       first_err_index,
  output logic [DATA_W-1:0] first_err_data,
  output logic              sync_err,
  output logic [31:0]       bit_error_count
);

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  logic [DATA_W-1:0]        gen_word;
  logic [CHECK_LATENCY-1:0] pipe_valid;
  logic [DATA_W-1:0]        pipe_word [CHECK_LATENCY];
  logic                     tail_valid;
  logic [DATA_W-1:0]        tail_word;
  logic                     do_check;
  logic                     word_error;

  stream_pattern_gen u_gen (
    .okClk         (okClk),
    .reset         (reset),
    .reset_pattern (reset_pattern),
    .pattern_sel   (pattern_sel),
    .enable        (enable),
    .word          (gen_word)
  );

  // Expected pipe. Stage 0 captures the generator value before it
  // advances, tagged with whether this cycle was a read strobe; the tail
  // therefore lines up with the valid strobe CHECK_LATENCY cycles later.
  // reset_pattern only drops the valid bits so stale words never match.
  always_ff @(posedge okClk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < CHECK_LATENCY; i++) begin
        pipe_word[i] <= '0;
      end
    end else if (reset_pattern) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= enable;
      pipe_word[0]  <= gen_word;
      for (int i = 1; i < CHECK_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_word[i]  <= pipe_word[i-1];
      end
    end
  end

  assign tail_valid   = pipe_valid[CHECK_LATENCY-1];
  assign tail_word    = pipe_word[CHECK_LATENCY-1];
  assign expected_out = tail_word;

  // A check that finds no expected word is both a sync error and a word
  // error, so a stream that runs ahead of the generator is never silent.
  assign do_check   = check && !reset_pattern;
  assign word_error = !tail_valid || (data_in != tail_word);

  // Counters and first-error capture. The captured index is the count
  // before this check increments it, i.e. the zero-based word number.
  always_ff @(posedge okClk) begin
    if (reset) begin
      word_count      <= '0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_data  <= '0;
      sync_err        <= 1'b0;
    end else if (do_check) begin
      word_count <= word_count + 32'd1;
      if (!tail_valid) begin
        sync_err <= 1'b1;
      end
      if (word_error) begin
        if (error_count != COUNT_MAX) begin
          error_count <= error_count + 32'd1;
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_index <= word_count;
          first_err_data  <= data_in;
        end
      end
    end
  end

`ifdef BIT_ERROR_COUNT_EN
  logic [6:0]  pop_bits;
  logic        pop_valid;
  logic [31:0] bit_errors;
  logic [32:0] bit_sum;

  // Popcount is registered first to keep the 64-bit XOR/adder tree off
  // the accumulator path. Only checks that had a real expected word
  // contribute; sync errors carry no meaningful bit difference.
  always_ff @(posedge okClk) begin
    if (reset) begin
      pop_valid <= 1'b0;
      pop_bits  <= '0;
    end else begin
      pop_valid <= do_check && tail_valid;
      pop_bits  <= 7'($countones(data_in ^ tail_word));
    end
  end

  assign bit_sum = {1'b0, bit_errors} + {26'd0, pop_bits};

  // Saturating accumulator, cleared only by reset.
  always_ff @(posedge okClk) begin
    if (reset) begin
      bit_errors <= '0;
    end else if (pop_valid) begin
      bit_errors <= bit_sum[32] ? COUNT_MAX : bit_sum[31:0];
    end
  end

  assign bit_error_count = bit_errors;
`else
  assign bit_error_count = '0;
`endif

endmodule
